regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Sequential read-side initiator for the 32x32 register file. On a start pulse it walks the file's synchronous read port (address in, data one clock later) from register 0 upward. It streams each register value out on a valid/ready interface with full backpressure support. It sits between the register file's spare read port and the debug/trace path, and is used for register snapshots after a test program halts.

Parameters:
NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1); legal range 1..2^ADDR_W
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  single-cycle request to begin a dump; ignored while busy=1
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the final output handshake
rf_addr  output  ADDR_W  register file read address; sampled by the file at posedge
rf_rdata  input  DATA_W  register file read data; valid the cycle after rf_addr is sampled
out_valid  output  1  out_data/out_idx/out_last hold a valid word
out_ready  input  1  downstream accepts the word when out_valid&&out_ready at posedge
out_data  output  DATA_W  register value
out_idx  output  ADDR_W  register index of out_data
out_last  output  1  marks the final word of the dump

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: busy=0, done=0, rf_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0. Reset also sets state IDLE, issue counter 0, in-flight flag 0, and empties the buffer.
- FSM states are IDLE, ISSUE, DRAIN, FINISH.
- IDLE: start=1 -> ISSUE; issue counter=0, busy=1 next cycle.
- ISSUE: each cycle, a read is issued when (buffer occupancy + in-flight) < 2.
  - Issuing drives rf_addr=counter, sets in_flight, and increments the counter.
  - After issuing index NUM_REGS-1 -> DRAIN.
- In-flight capture: the cycle after issue, rf_rdata is written into the 2-entry output FIFO together with its index. Each entry is {data, idx, last}, with last=(idx==NUM_REGS-1).
- rf_addr holds its last issued value when not issuing. It is never used as a write address.
- Output FIFO: 2 entries, registered outputs driven from the head entry.
  - out_valid = occupancy != 0.
  - Capture and pop in the same cycle are legal; occupancy is unchanged.
  - Capture is never blocked: the issue rule guarantees space.
- Throughput: with out_ready held at 1, one word per cycle after a 2-cycle startup.
  - start accepted at edge T0: first rf_addr issue sampled at T1, first out_valid visible after T2.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_idx/out_last are stable.
- DRAIN: wait until the FIFO is empty and no read is in flight -> FINISH.
- FINISH: done=1 for one cycle, busy=0 from the next cycle -> IDLE.
- start in the same cycle as done is ignored. A start the following cycle is accepted.
- Boundaries:
  - NUM_REGS=1: single word with out_last=1.
  - Counter width is ADDR_W+1 so that NUM_REGS=2^ADDR_W terminates without wrap.
  - Reset mid-dump: immediate abort to IDLE, all outputs return to reset values. No done pulse and no further words.
- The block reads register 0 like any other index; the register file guarantees it returns 0.

Optional Feature:
REGDUMP_CHECKSUM_EN
- Defined: after register NUM_REGS-1, one extra word is emitted with out_data = XOR of all dumped values and out_idx=0.
  - out_last is asserted only on the checksum word; register NUM_REGS-1 has out_last=0.
  - The checksum accumulator clears on accepted start and updates on each register-word handshake.
  - DRAIN waits for the checksum word's handshake before FINISH.
- Undefined: no accumulator and no extra word; out_last is set on register NUM_REGS-1.

Test Plan:
- Preload reg5=0x5, reg6=0x4, all others 0; pulse start with out_ready=1 -> 32 words, idx 0..31 in order, idx5=0x5, idx6=0x4, out_last only on idx31, done one cycle after that handshake. Same preload with REGDUMP_CHECKSUM_EN defined -> 33 words; the final word is data 0x1 with out_last=1.
- out_ready toggled 1,0,0,1 repeatedly -> no word lost or duplicated; data stable while stalled; occupancy never exceeds 2.
- out_ready=0 for 10 cycles after start -> at most 2 reads issued before the stall; rf_addr does not advance until the first pop.
- start pulsed again while busy at idx 10 -> ignored; exactly 32 words and one done pulse.
- rst asserted at idx 17 mid-stall -> outputs at reset values on the next edge with no done pulse; a new start dumps idx 0..31 correctly.
- NUM_REGS=1 build -> single word idx0=0x0 with out_last=1, then done.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Bus bundle for regfile_dump_reader: register-file read port plus the output word stream.
// The master modport is the dump reader; the slave modport is the register file and sink side.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;

  modport master (
    output rf_addr,
    input  rf_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_idx,
    output out_last
  );

  modport slave (
    input  rf_addr,
    output rf_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_idx,
    input  out_last
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file read port from index 0 upward and streams every value out with valid/ready.
// Optional REGDUMP_CHECKSUM_EN appends an XOR-of-all-values word (idx 0) as the final, last-flagged word.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  regfile_dump_reader_if.master bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } entry_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [ADDR_W-1:0] fl_idx_q;
  logic              in_flight_q;
  logic              busy_q;
  logic              done_q;
  entry_t            head_q;
  entry_t            tail_q;
  logic [1:0]        occ_q;

  logic              pop;
  logic              issue;
  logic              push;
  logic              drained_next;
  logic              finish_go;
  logic [2:0]        committed;
  logic [1:0]        occ_d;
  entry_t            cap_entry;
  entry_t            push_entry;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] csum_d;
  logic              csum_sent_q;
  logic              push_csum;
`else
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
`endif

  always_comb begin
    pop = (occ_q != 2'd0) && bus.out_ready;
    // Slots still claimed after this edge; a word issued now lands two edges out, so a pop
    // this cycle already frees room for it and keeps the stream at one word per cycle.
    committed    = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
    issue        = (state_q == ISSUE) && (committed < 3'd2);
    drained_next = !in_flight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));

    cap_entry.data = bus.rf_rdata;
    cap_entry.idx  = fl_idx_q;
`ifdef REGDUMP_CHECKSUM_EN
    cap_entry.last = 1'b0;
    csum_d     = (pop && !csum_sent_q) ? (csum_q ^ head_q.data) : csum_q;
    push_csum  = (state_q == DRAIN) && drained_next && !csum_sent_q;
    finish_go  = (state_q == DRAIN) && drained_next && csum_sent_q;
    push       = in_flight_q || push_csum;
    push_entry = in_flight_q ? cap_entry : '{data: csum_d, idx: '0, last: 1'b1};
`else
    cap_entry.last = (fl_idx_q == LAST_IDX);
    finish_go  = (state_q == DRAIN) && drained_next;
    push       = in_flight_q;
    push_entry = cap_entry;
`endif
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rf_addr_q   <= '0;
      fl_idx_q    <= '0;
      in_flight_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= 2'd0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q      <= '0;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ISSUE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (finish_go) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase

      in_flight_q <= issue;
      if (issue) begin
        rf_addr_q <= cnt_q[ADDR_W-1:0];
        fl_idx_q  <= cnt_q[ADDR_W-1:0];
      end

      // Two-entry FIFO; head_q always feeds the outputs directly.
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= push_entry;
          else               tail_q <= push_entry;
        end
        2'b01: head_q <= tail_q;
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= push_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= push_entry;
          end
        end
        default: ;
      endcase
      occ_q <= occ_d;

`ifdef REGDUMP_CHECKSUM_EN
      if (state_q == IDLE && start) begin
        csum_q      <= '0;
        csum_sent_q <= 1'b0;
      end else begin
        csum_q <= csum_d;
        if (push_csum) csum_sent_q <= 1'b1;
      end
`endif
    end
  end

  // Not issuing: hold the last issued address.
  assign bus.rf_addr   = issue ? cnt_q[ADDR_W-1:0] : rf_addr_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = head_q.data;
  assign bus.out_idx   = head_q.idx;
  assign bus.out_last  = head_q.last;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: scenario table plus hand sequences, scored against a queue built
// directly from the register contents (plus the XOR word when REGDUMP_CHECKSUM_EN is defined).
module tb_regfile_dump_reader;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int W = N + CS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } word_t;

  typedef struct {
    int ready_mode;     // 0 always, 1 pattern 1001, 2 random, 3 stalled for 10 cycles
    int preload;        // 0 reg5=5/reg6=4, 1 random
    int restart_at;     // words received before a start pulse while busy, -1 none
    bit start_on_done;
    int exp_words;
    int exp_done_tick;  // -1 when latency is not checked
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic busy, done, busy1, done1;

  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  regfile_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  regfile_dump_reader #(.NUM_REGS(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf_mem [N];
  always @(posedge clk) begin
    bus.rf_rdata  <= rf_mem[bus.rf_addr];
    bus1.rf_rdata <= rf_mem[bus1.rf_addr];
  end

  int    tests = 0;
  int    fails = 0;
  word_t exp_q[$];
  bit    mon_en = 1'b0;
  int    rx_words, done_cnt;
  bit    prev_vld, prev_rdy, final_hs_prev;
  word_t prev_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    word_t w, e;
    w = {bus.out_data, bus.out_idx, bus.out_last};
    if (prev_vld && !prev_rdy) begin
      check("stall_valid_held", bus.out_valid, 1);
      check("stall_word_stable", w, prev_w);
    end
    if (final_hs_prev) check("done_after_last", done, 1);
    else if (done)     check("done_unexpected", done, 0);
    if (done) done_cnt++;
    final_hs_prev = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      rx_words++;
      if (exp_q.size() == 0) begin
        check("extra_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("word%0d", rx_words - 1), w, e);
        final_hs_prev = (exp_q.size() == 0);
      end
    end
    prev_vld = bus.out_valid;
    prev_rdy = bus.out_ready;
    prev_w   = w;
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int mode);
    for (int i = 0; i < N; i++) rf_mem[i] = (mode == 0) ? '0 : $urandom;
    if (mode == 0) begin
      rf_mem[5] = 32'h5;
      rf_mem[6] = 32'h4;
    end
    rf_mem[0] = '0;
  endtask

  task automatic begin_dump();
    logic [DW-1:0] x;
    exp_q.delete();
    x = '0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back('{data: rf_mem[i], idx: AW'(i), last: (CS == 0) && (i == N - 1)});
      x ^= rf_mem[i];
    end
    if (CS != 0) exp_q.push_back('{data: x, idx: '0, last: 1'b1});
    rx_words = 0;
    done_cnt = 0;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    final_hs_prev = 1'b0;
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       return 1'($urandom_range(0, 1));
      3:       return cyc >= 10;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_done(input string name, input int exp_words);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      bus.out_ready = 1'b1;
      tick();
      cyc++;
    end
    check({name, "_timeout"}, cyc < 2000, 1);
    check({name, "_words"}, rx_words, exp_words);
  endtask

  task automatic run_dump(input vec_t v);
    int cyc;
    int done_tick = -1;
    bit restarted = 1'b0;
    preload(v.preload);
    begin_dump();
    bus.out_ready = rdy(v.ready_mode, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 1;
    while (done_cnt == 0 && cyc < 2000) begin
      bus.out_ready = rdy(v.ready_mode, cyc);
      start = 1'b0;
      if (v.restart_at >= 0 && !restarted && rx_words >= v.restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (v.start_on_done && cyc == v.exp_done_tick) start = 1'b1;
      tick();
      if (v.ready_mode == 3 && cyc == 9) begin
        check("stall_rf_addr", bus.rf_addr, 1);
        check("stall_head_idx", {bus.out_valid, bus.out_idx}, {1'b1, 5'd0});
      end
      if (done_cnt != 0) done_tick = cyc;
      cyc++;
    end
    start = 1'b0;
    check("dump_timeout", cyc < 2000, 1);
    check("dump_words", rx_words, v.exp_words);
    check("dump_queue_empty", exp_q.size(), 0);
    if (v.exp_done_tick >= 0) check("done_latency", done_tick, v.exp_done_tick);
    if (v.start_on_done) begin
      check("start_with_done_ignored", busy, 0);
      begin_dump();
      bus.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_after_done_accepted", busy, 1);
      wait_done("redump", W);
    end
    repeat (3) tick();
    check("done_single_pulse", done_cnt, 1);
    check("busy_cleared", busy, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_rf_addr"}, bus.rf_addr, 0);
    check({pfx, "_out_valid"}, bus.out_valid, 0);
    check({pfx, "_out_data"}, bus.out_data, 0);
    check({pfx, "_out_idx"}, bus.out_idx, 0);
    check({pfx, "_out_last"}, bus.out_last, 0);
  endtask

  vec_t tbl[5];

  initial begin
    int cyc, act_cnt, n1_words, n1_done;
    logic n1_last;

    tbl[0] = '{0, 0, -1, 1'b0, W, W + 3};
    tbl[1] = '{1, 1, -1, 1'b0, W, -1};
    tbl[2] = '{3, 1, -1, 1'b0, W, -1};
    tbl[3] = '{2, 1, 10, 1'b0, W, -1};
    tbl[4] = '{0, 1, -1, 1'b1, W, W + 3};

    bus.out_ready  = 1'b0;
    bus1.out_ready = 1'b0;
    preload(0);
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_dump(tbl[i]);

    // Reset while stalled on index 17.
    preload(1);
    begin_dump();
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(bus.out_valid && bus.out_idx == 5'd17) && cyc < 200) begin
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("reach_idx17", cyc < 200, 1);
    repeat (2) tick();
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    act_cnt = 0;
    repeat (6) begin
      tick();
      if (bus.out_valid || done || busy) act_cnt++;
    end
    check("abort_no_activity", act_cnt, 0);
    mon_en = 1'b1;
    run_dump('{0, 1, -1, 1'b0, W, W + 3});

    // Single-register instance.
    bus1.out_ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n1_words = 0;
    n1_done = 0;
    n1_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus1.out_valid) begin
        n1_words++;
        if (n1_words == 1) begin
          check("n1_idx", bus1.out_idx, 0);
          check("n1_data", bus1.out_data, 0);
          check("n1_first_last", bus1.out_last, (CS == 0));
        end
        n1_last = bus1.out_last;
      end
      if (done1) n1_done++;
      tick();
    end
    check("n1_words", n1_words, 1 + CS);
    check("n1_final_last", n1_last, 1);
    check("n1_done_count", n1_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
